// File: rtl/my_td4.sv
`default_nettype none
//============================================================================
// Module      : my_td4
// Description : 4-bit single-cycle TD4-class CPU. Two general registers
//               (A, B), a carry flag, a 4-bit output register driving the
//               LEDs and a 16-word external program ROM fetched
//               combinationally from the program counter. One instruction
//               executes per rising edge of CLK.
//               Optional macro MY_TD4_IN_SYNC_EN inserts a two-flop
//               synchronizer on sw_in ahead of the IN instructions.
// Revision    : 1.0 - initial release
//============================================================================
module my_td4 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] sw_in,
    input  logic [7:0] mem0,
    input  logic [7:0] mem1,
    input  logic [7:0] mem2,
    input  logic [7:0] mem3,
    input  logic [7:0] mem4,
    input  logic [7:0] mem5,
    input  logic [7:0] mem6,
    input  logic [7:0] mem7,
    input  logic [7:0] mem8,
    input  logic [7:0] mem9,
    input  logic [7:0] memA,
    input  logic [7:0] memB,
    input  logic [7:0] memC,
    input  logic [7:0] memD,
    input  logic [7:0] memE,
    input  logic [7:0] memF,
    output logic [3:0] led
);

    // Opcode encodings (instruction bits [7:4])
    localparam logic [3:0] c_OP_ADD_A  = 4'b0000;
    localparam logic [3:0] c_OP_MOV_AB = 4'b0001;
    localparam logic [3:0] c_OP_IN_A   = 4'b0010;
    localparam logic [3:0] c_OP_MOV_AI = 4'b0011;
    localparam logic [3:0] c_OP_MOV_BA = 4'b0100;
    localparam logic [3:0] c_OP_ADD_B  = 4'b0101;
    localparam logic [3:0] c_OP_IN_B   = 4'b0110;
    localparam logic [3:0] c_OP_MOV_BI = 4'b0111;
    localparam logic [3:0] c_OP_OUT_B  = 4'b1001;
    localparam logic [3:0] c_OP_OUT_I  = 4'b1011;
    localparam logic [3:0] c_OP_JNC    = 4'b1110;
    localparam logic [3:0] c_OP_JMP    = 4'b1111;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_pc;
    logic       r_c;
    logic [3:0] r_out;

    logic [7:0] w_inst;
    logic [3:0] w_op;
    logic [3:0] w_im;
    logic [3:0] w_sw;
    logic [4:0] w_sum_a;
    logic [4:0] w_sum_b;
    logic [3:0] w_a_nxt;
    logic [3:0] w_b_nxt;
    logic [3:0] w_pc_nxt;
    logic       w_c_nxt;
    logic [3:0] w_out_nxt;

`ifdef MY_TD4_IN_SYNC_EN
    logic [3:0] r_sw_meta;
    logic [3:0] r_sw_sync;

    // Two-flop synchronizer: IN sees a switch change two edges later
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sw_meta <= 4'd0;
            r_sw_sync <= 4'd0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw = r_sw_sync;
`else
    assign w_sw = sw_in;
`endif

    // Instruction fetch: ROM word selected by the program counter
    always_comb begin
        w_inst = mem0;
        case (r_pc)
            4'h0: w_inst = mem0;
            4'h1: w_inst = mem1;
            4'h2: w_inst = mem2;
            4'h3: w_inst = mem3;
            4'h4: w_inst = mem4;
            4'h5: w_inst = mem5;
            4'h6: w_inst = mem6;
            4'h7: w_inst = mem7;
            4'h8: w_inst = mem8;
            4'h9: w_inst = mem9;
            4'hA: w_inst = memA;
            4'hB: w_inst = memB;
            4'hC: w_inst = memC;
            4'hD: w_inst = memD;
            4'hE: w_inst = memE;
            4'hF: w_inst = memF;
        endcase
    end

    assign w_op    = w_inst[7:4];
    assign w_im    = w_inst[3:0];
    assign w_sum_a = {1'b0, r_a} + {1'b0, w_im};
    assign w_sum_b = {1'b0, r_b} + {1'b0, w_im};

    // Decode/execute: carry clears unless an ADD sets it; PC advances unless a jump is taken
    always_comb begin
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_out_nxt = r_out;
        w_pc_nxt  = r_pc + 4'd1;
        w_c_nxt   = 1'b0;
        case (w_op)
            c_OP_ADD_A:  {w_c_nxt, w_a_nxt} = w_sum_a;
            c_OP_ADD_B:  {w_c_nxt, w_b_nxt} = w_sum_b;
            c_OP_MOV_AI: w_a_nxt = w_im;
            c_OP_MOV_BI: w_b_nxt = w_im;
            c_OP_MOV_AB: w_a_nxt = r_b;
            c_OP_MOV_BA: w_b_nxt = r_a;
            c_OP_IN_A:   w_a_nxt = w_sw;
            c_OP_IN_B:   w_b_nxt = w_sw;
            c_OP_OUT_B:  w_out_nxt = r_b;
            c_OP_OUT_I:  w_out_nxt = w_im;
            c_OP_JMP:    w_pc_nxt = w_im;
            c_OP_JNC:    if (!r_c) w_pc_nxt = w_im;
            default:     ;
        endcase
    end

    // Architectural state update; reset overrides any instruction
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_pc  <= 4'd0;
            r_c   <= 1'b0;
            r_out <= 4'd0;
        end else begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_pc  <= w_pc_nxt;
            r_c   <= w_c_nxt;
            r_out <= w_out_nxt;
        end
    end

    assign led = r_out;

endmodule
`default_nettype wire

// File: tb/tb_my_td4.sv
`default_nettype none
//============================================================================
// Module      : tb_my_td4
// Description : Self-checking bench for my_td4. A behavioural model of the
//               instruction set runs alongside the core; directed programs
//               cover reset, OUT, the carry loop, IN/OUT, jumps and PC wrap,
//               followed by random programs with random switch inputs.
// Revision    : 1.0 - initial release
//============================================================================
module tb_my_td4;

    logic       CLK;
    logic       RST;
    logic [3:0] sw_in;
    logic [7:0] rom [16];
    logic [3:0] led;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int ma, mb, mpc, mc, mout;
    int swd1, swd2;

    my_td4 dut (
        .CLK   (CLK),
        .RST   (RST),
        .sw_in (sw_in),
        .mem0  (rom[0]),  .mem1 (rom[1]),  .mem2 (rom[2]),  .mem3 (rom[3]),
        .mem4  (rom[4]),  .mem5 (rom[5]),  .mem6 (rom[6]),  .mem7 (rom[7]),
        .mem8  (rom[8]),  .mem9 (rom[9]),  .memA (rom[10]), .memB (rom[11]),
        .memC  (rom[12]), .memD (rom[13]), .memE (rom[14]), .memF (rom[15]),
        .led   (led)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One instruction of the ISA applied to the model state
    task automatic model_edge();
        int op, im, sw, sum, npc, nc;
        if (RST === 1'b0) begin
            ma = 0; mb = 0; mpc = 0; mc = 0; mout = 0; swd1 = 0; swd2 = 0;
            return;
        end
        op = int'(rom[mpc]) / 16;
        im = int'(rom[mpc]) % 16;
`ifdef MY_TD4_IN_SYNC_EN
        sw = swd2;
        swd2 = swd1;
        swd1 = int'(sw_in);
`else
        sw = int'(sw_in);
`endif
        npc = (mpc + 1) % 16;
        nc  = 0;
        case (op)
            0:  begin sum = ma + im; ma = sum % 16; nc = sum / 16; end
            5:  begin sum = mb + im; mb = sum % 16; nc = sum / 16; end
            3:  ma = im;
            7:  mb = im;
            1:  ma = mb;
            4:  mb = ma;
            2:  ma = sw;
            6:  mb = sw;
            9:  mout = mb;
            11: mout = im;
            15: npc = im;
            14: if (mc == 0) npc = im;
            default: ;
        endcase
        mpc = npc;
        mc  = nc;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".led"}, {4'd0, led},           8'(mout));
        chk({tag, ".pc"},  {4'd0, dut.r_pc},      8'(mpc));
        chk({tag, ".a"},   {4'd0, dut.r_a},       8'(ma));
        chk({tag, ".b"},   {4'd0, dut.r_b},       8'(mb));
        chk({tag, ".c"},   {7'd0, dut.r_c},       8'(mc));
    endtask

    // Advance one edge, step the model, then compare away from the edge
    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b0;
        tick(tag);
        RST = 1'b1;
    endtask

    initial begin
        RST   = 1'b0;
        sw_in = 4'd0;
        rand_rom();

        // Reset with arbitrary ROM
        do_reset("reset");
        chk("reset.led0", {4'd0, led},      8'd0);
        chk("reset.pc0",  {4'd0, dut.r_pc}, 8'd0);

        // OUT immediate
        rand_rom();
        rom[0] = 8'hB7;
        do_reset("out_rst");
        tick("out_imm");
        chk("out_imm.led7", {4'd0, led},      8'd7);
        chk("out_imm.pc1",  {4'd0, dut.r_pc}, 8'd1);

        // Carry loop: A counts up, wraps with carry on edge 32
        rand_rom();
        rom[0] = 8'hB7; rom[1] = 8'h01; rom[2] = 8'hE1; rom[3] = 8'h01;
        do_reset("loop_rst");
        for (int e = 1; e <= 34; e++) begin
            tick("loop");
            if (e == 32) begin
                chk("loop.wrap_a", {4'd0, dut.r_a}, 8'd0);
                chk("loop.wrap_c", {7'd0, dut.r_c}, 8'd1);
            end
            if (e == 33) chk("loop.fall_pc", {4'd0, dut.r_pc}, 8'd3);
            if (e == 34) begin
                chk("loop.m3_a", {4'd0, dut.r_a}, 8'd1);
                chk("loop.m3_c", {7'd0, dut.r_c}, 8'd0);
            end
        end

        // Reset mid-run during the carry loop
        do_reset("loop_rst");
        for (int e = 0; e < 7; e++) tick("loop2");
        chk("midrst.led_pre", {4'd0, led}, 8'd7);
        do_reset("midrst");
        chk("midrst.led0", {4'd0, led},      8'd0);
        chk("midrst.pc0",  {4'd0, dut.r_pc}, 8'd0);
        tick("midrst_rel");
        chk("midrst.led7", {4'd0, led}, 8'd7);

        // IN B / OUT B
        rand_rom();
        sw_in = 4'h5;
`ifdef MY_TD4_IN_SYNC_EN
        rom[0] = 8'h80; rom[1] = 8'h80; rom[2] = 8'h60; rom[3] = 8'h90;
        do_reset("inout_rst");
        for (int e = 0; e < 4; e++) tick("inout");
`else
        rom[0] = 8'h60; rom[1] = 8'h90;
        do_reset("inout_rst");
        for (int e = 0; e < 2; e++) tick("inout");
`endif
        chk("inout.led5", {4'd0, led}, 8'd5);

        // JMP F self-loop holds PC and led
        rand_rom();
        rom[0] = 8'hB9; rom[1] = 8'hFF; rom[15] = 8'hFF;
        do_reset("jmpf_rst");
        for (int e = 0; e < 6; e++) tick("jmpf");
        chk("jmpf.pc", {4'd0, dut.r_pc}, 8'd15);
        chk("jmpf.led", {4'd0, led},     8'd9);

        // PC wraps F -> 0
        rom[0] = 8'hFF; rom[15] = 8'h00;
        do_reset("wrap_rst");
        tick("wrap");
        tick("wrap");
        chk("wrap.pc0", {4'd0, dut.r_pc}, 8'd0);

        // JMP A from 5 clears a pending carry
        rand_rom();
        rom[0] = 8'h31; rom[1] = 8'h80; rom[2] = 8'h80; rom[3] = 8'h80;
        rom[4] = 8'h0F; rom[5] = 8'hFA;
        do_reset("jmpa_rst");
        for (int e = 0; e < 5; e++) tick("jmpa");
        chk("jmpa.c_pre", {7'd0, dut.r_c}, 8'd1);
        tick("jmpa");
        chk("jmpa.pc", {4'd0, dut.r_pc}, 8'd10);
        chk("jmpa.c",  {7'd0, dut.r_c},  8'd0);

        // Random programs, random switches, occasional reset
        for (int p = 0; p < 25; p++) begin
            rand_rom();
            do_reset("rnd_rst");
            for (int e = 0; e < 48; e++) begin
                sw_in = 4'($urandom);
                RST = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
                tick("rnd");
            end
            RST = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
